// File: rtl/ecc_keygen_sched.sv
// ecc_keygen_sched: round-robin arbiter and sequencer sharing one EC point-multiply engine between two requesters
module ecc_keygen_sched #(
    parameter int KEY_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*KEY_BYTES*8-1:0]  req_scalar,
    input  logic [15:0]               req_len,
    output logic                      eng_start,
    output logic                      eng_abort,
    output logic [KEY_BYTES*8-1:0]    eng_scalar,
    input  logic                      eng_done,
    input  logic                      eng_err,
    input  logic [KEY_BYTES*8-1:0]    eng_x,
    input  logic [KEY_BYTES*8-1:0]    eng_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_byte,
    output logic                      out_last,
    output logic                      out_id,
    output logic                      out_err
);
    localparam int W  = KEY_BYTES*8;
    localparam int CW = $clog2(TIMEOUT_CYCLES+1);
    localparam int IW = $clog2(KEY_BYTES+1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] HDR   = 3'd4;
    localparam logic [2:0] EMX   = 3'd5;
    localparam logic [2:0] EMY   = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;

    logic [2:0]    state;
    logic          ptr, id, g, beat, last_idx, expire;
    logic [W-1:0]  scalar, xs, ys;
    logic [7:0]    len, code;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    always_comb begin
        g          = req_valid[ptr] ? ptr : ~ptr;
        req_ready  = (!rst && state == IDLE && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
        last_idx   = idx == IW'(KEY_BYTES-1);
        expire     = state == WAIT && cnt == CW'(TIMEOUT_CYCLES-1);
        eng_start  = state == START;
        eng_abort  = expire && !eng_done;
        eng_scalar = (state == START || state == WAIT) ? scalar : '0;
        out_valid  = state == HDR || state == EMX || state == EMY || state == ERR;
        // X and Y are shifted left per beat, so the current byte is always the top one
        out_byte   = state == HDR ? 8'h04 :
                     state == EMX ? xs[W-1 -: 8] :
                     state == EMY ? ys[W-1 -: 8] :
                     state == ERR ? code : 8'h00;
        out_last   = state == ERR || (state == EMY && last_idx);
        out_id     = out_valid && id;
        out_err    = state == ERR;
        beat       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            id     <= 1'b0;
            scalar <= '0;
            len    <= '0;
            code   <= '0;
            cnt    <= '0;
            idx    <= '0;
            xs     <= '0;
            ys     <= '0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    id     <= g;
                    ptr    <= ~g;
                    scalar <= g ? req_scalar[2*W-1 -: W] : req_scalar[W-1:0];
                    len    <= g ? req_len[15:8] : req_len[7:0];
                    state  <= CHECK;
                end
                CHECK: begin
                    code  <= len != 8'(KEY_BYTES) ? 8'h01 : 8'h02;
                    state <= (len != 8'(KEY_BYTES) || scalar == '0) ? ERR : START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a result on the expiry cycle takes precedence over the timeout
                    if (eng_done && !eng_err) begin
                        xs    <= eng_x;
                        ys    <= eng_y;
                        state <= HDR;
                    end else if (eng_done || expire) begin
                        code  <= eng_done ? 8'h03 : 8'h04;
                        state <= ERR;
                    end
                end
                HDR: if (beat) state <= EMX;
                EMX: if (beat) begin
                    xs    <= xs << 8;
                    idx   <= last_idx ? '0 : idx + 1'b1;
                    state <= last_idx ? EMY : EMX;
                end
                EMY: if (beat) begin
                    ys    <= ys << 8;
                    idx   <= last_idx ? '0 : idx + 1'b1;
                    state <= last_idx ? IDLE : EMY;
                end
                default: if (beat) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_keygen_sched.sv
// tb_ecc_keygen_sched: scoreboard bench for the shared keygen scheduler with a behavioural engine
module tb_ecc_keygen_sched;
    localparam int KB = 32;
    localparam int W  = KB*8;
    localparam int TO = 16;
    localparam logic [W-1:0] GX = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    localparam logic [W-1:0] GY = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       id;
        logic       err;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [2*W-1:0] req_scalar = '0;
    logic [15:0]  req_len = '0;
    logic         eng_start, eng_abort;
    logic [W-1:0] eng_scalar;
    logic         eng_done = 1'b0;
    logic         eng_err = 1'b0;
    logic [W-1:0] eng_x = GX;
    logic [W-1:0] eng_y = GY;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_byte;
    logic         out_last, out_id, out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int aborts = 0;
    int beats = 0;
    int start_cyc = 0;
    int abort_cyc = 0;
    int done_cyc = 0;
    int first_valid_cyc = 0;
    int eng_lat = 10;
    logic [W-1:0] start_scalar = '0;
    logic eng_err_mode = 1'b0;
    logic rdy_mode = 1'b0;
    logic stale_mode = 1'b0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_out = '0;
    beat_t sbq[$];

    ecc_keygen_sched #(.KEY_BYTES(KB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_scalar(req_scalar), .req_len(req_len),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_scalar(eng_scalar),
        .eng_done(eng_done), .eng_err(eng_err), .eng_x(eng_x), .eng_y(eng_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .out_id(out_id), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_mode ? ~out_ready : 1'b1;
    end

    // engine model: result eng_lat cycles after the start pulse; optional stale pulse after a reset
    always begin
        @(negedge clk);
        if (eng_start && eng_lat >= 0) begin
            repeat (eng_lat) @(posedge clk);
            #1;
            eng_done = 1'b1;
            eng_err  = eng_err_mode;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            eng_err  = 1'b0;
        end else if (stale_mode && rst) begin
            while (rst) @(negedge clk);
            repeat (2) @(posedge clk);
            #1;
            eng_done = 1'b1;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (eng_start) begin
            starts++;
            start_cyc = cyc;
            start_scalar = eng_scalar;
        end
        if (eng_abort) begin
            aborts++;
            abort_cyc = cyc;
        end
        if (eng_done) done_cyc = cyc;
        if (out_valid && !prev_out[11]) first_valid_cyc = cyc;
        if (!rst && prev_stall) begin
            checks++;
            if ({out_valid, out_byte, out_last, out_id, out_err} !== prev_out[11:0]) begin
                errors++;
                $display("FAIL stall_hold got %h want %h", {out_valid, out_byte, out_last, out_id, out_err}, prev_out);
            end
        end
        if (!rst && out_valid && out_ready) begin
            checks++;
            beats++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got byte %h last %b id %b err %b want none", out_byte, out_last, out_id, out_err);
            end else begin
                e = sbq.pop_front();
                if ({out_byte, out_last, out_id, out_err} !== e) begin
                    errors++;
                    $display("FAIL beat_%0d got %h want %h", beats, {out_byte, out_last, out_id, out_err}, e);
                end
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_out   = {out_valid, out_valid, out_byte, out_last, out_id, out_err};
    end

    task automatic push_ok(input logic id, input logic [W-1:0] x, input logic [W-1:0] y);
        sbq.push_back({8'h04, 1'b0, id, 1'b0});
        for (int i = 0; i < KB; i++) sbq.push_back({x[W-1-8*i -: 8], 1'b0, id, 1'b0});
        for (int i = 0; i < KB; i++) sbq.push_back({y[W-1-8*i -: 8], i == KB-1, id, 1'b0});
    endtask

    task automatic push_err(input logic id, input logic [7:0] code);
        sbq.push_back({code, 1'b1, id, 1'b1});
    endtask

    task automatic do_req(input int r, input logic [7:0] l, input logic [W-1:0] s, output int t);
        @(posedge clk);
        #1;
        req_scalar[r*W +: W] = s;
        req_len[r*8 +: 8] = l;
        req_valid[r] = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        for (int i = 0; i < 600 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        left = sbq.size();
        sbq.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, eng_start, eng_abort, out_valid, out_byte, out_last, out_id, out_err} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {req_ready, eng_start, eng_abort, out_valid, out_byte, out_last, out_id, out_err});
        end
        checks++;
        if (eng_scalar !== '0) begin
            errors++;
            $display("FAIL reset_eng_scalar got %h want 0", eng_scalar);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_generator;
        int t, left, s0;
        s0 = starts;
        eng_lat = 10;
        do_req(0, 8'd32, 256'd1, t);
        checks++;
        if (t < 0) begin errors++; $display("FAIL gen_grant got none want handshake"); end
        push_ok(1'b0, GX, GY);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL gen_drain got %0d beats left want 0", left); end
        checks++;
        if (start_cyc != t + 2 || starts != s0 + 1) begin
            errors++;
            $display("FAIL gen_start_latency got cycle %0d count %0d want cycle %0d count %0d", start_cyc, starts - s0, t + 2, 1);
        end
        checks++;
        if (start_scalar !== 256'd1) begin errors++; $display("FAIL gen_eng_scalar got %h want 1", start_scalar); end
        checks++;
        if (done_cyc != start_cyc + 10 || first_valid_cyc != done_cyc + 1) begin
            errors++;
            $display("FAIL gen_hdr_latency got hdr %0d done %0d want hdr %0d", first_valid_cyc, done_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_len_err;
        int t, left, s0;
        s0 = starts;
        do_req(1, 8'd31, {W{1'b1}}, t);
        checks++;
        if (t < 0) begin errors++; $display("FAIL len_grant got none want handshake"); end
        push_err(1'b1, 8'h01);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL len_drain got %0d beats left want 0", left); end
        checks++;
        if (starts != s0 || first_valid_cyc != t + 2) begin
            errors++;
            $display("FAIL len_timing got starts %0d beat cycle %0d want starts 0 beat cycle %0d", starts - s0, first_valid_cyc, t + 2);
        end
    endtask

    task automatic test_zero_scalar;
        int t, left, s0;
        s0 = starts;
        do_req(0, 8'd32, '0, t);
        push_err(1'b0, 8'h02);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL zero_drain got %0d beats left want 0", left); end
        checks++;
        if (starts != s0 || first_valid_cyc != t + 2) begin
            errors++;
            $display("FAIL zero_timing got starts %0d beat cycle %0d want starts 0 beat cycle %0d", starts - s0, first_valid_cyc, t + 2);
        end
    endtask

    task automatic test_timeout;
        int t, left, a0;
        a0 = aborts;
        eng_lat = -1;
        do_req(0, 8'd32, GY, t);
        push_err(1'b0, 8'h04);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL timeout_drain got %0d beats left want 0", left); end
        checks++;
        if (aborts != a0 + 1 || abort_cyc != start_cyc + TO) begin
            errors++;
            $display("FAIL timeout_abort got count %0d cycle %0d want count 1 cycle %0d", aborts - a0, abort_cyc, start_cyc + TO);
        end
        a0 = aborts;
        eng_lat = TO;
        do_req(1, 8'd32, GX, t);
        push_ok(1'b1, GX, GY);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL expiry_done_drain got %0d beats left want 0", left); end
        checks++;
        if (aborts != a0 || done_cyc != start_cyc + TO) begin
            errors++;
            $display("FAIL expiry_done_abort got aborts %0d done offset %0d want aborts 0 offset %0d", aborts - a0, done_cyc - start_cyc, TO);
        end
        eng_lat = 10;
    endtask

    task automatic test_engine_err;
        int t, left;
        eng_lat = 5;
        eng_err_mode = 1'b1;
        do_req(0, 8'd32, 256'h1234, t);
        push_err(1'b0, 8'h03);
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL engine_err_drain got %0d beats left want 0", left); end
        eng_err_mode = 1'b0;
        eng_lat = 10;
    endtask

    task automatic test_back_to_back;
        int left;
        logic [1:0] got;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1'b1;
        req_scalar = {256'hA5, 256'h5A};
        req_len = 16'h2020;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            eng_x = {8{$urandom}};
            eng_y = {8{$urandom}};
            got = 2'b00;
            for (int i = 0; i < 200 && got == 2'b00; i++) begin
                @(negedge clk);
                got = req_ready;
            end
            checks++;
            if (got !== (k[0] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant_%0d got %b want %b", k, got, k[0] ? 2'b10 : 2'b01);
            end
            push_ok(k[0], eng_x, eng_y);
            wait_drain(left);
            checks++;
            if (left != 0) begin errors++; $display("FAIL b2b_drain_%0d got %0d beats left want 0", k, left); end
        end
        req_valid = 2'b00;
        rdy_mode = 1'b0;
        eng_x = GX;
        eng_y = GY;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int t, left, b0, bad;
        logic [1:0] got;
        eng_lat = 10;
        stale_mode = 1'b1;
        b0 = beats;
        do_req(0, 8'd32, 256'd5, t);
        push_ok(1'b0, GX, GY);
        for (int i = 0; i < 200 && beats < b0 + 10; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        checks++;
        if ({req_ready, eng_start, eng_abort, out_valid, out_byte, out_last, out_id, out_err, eng_scalar} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got valid %b byte %h start %b ready %b want all 0", out_valid, out_byte, eng_start, req_ready);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || eng_start || eng_abort) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stale_done_ignored got %0d active cycles want 0", bad); end
        stale_mode = 1'b0;
        @(posedge clk);
        #1;
        req_scalar = {256'h77, 256'h99};
        req_len = 16'h2020;
        req_valid = 2'b11;
        got = 2'b00;
        for (int i = 0; i < 200 && got == 2'b00; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        checks++;
        if (got !== 2'b01) begin errors++; $display("FAIL post_reset_grant got %b want 01", got); end
        push_ok(1'b0, GX, GY);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL post_reset_drain got %0d beats left want 0", left); end
        checks++;
        if (start_scalar !== 256'h99) begin errors++; $display("FAIL post_reset_scalar got %h want 99", start_scalar); end
    endtask

    initial begin
        test_reset;
        test_generator;
        test_len_err;
        test_zero_scalar;
        test_timeout;
        test_engine_err;
        test_back_to_back;
        test_reset_mid;
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
